wb_align_stage: RTL and testbench
=================================

// Module: wb_align_stage
// PURPOSE
//  Writeback stage directly upstream of the 3-write-port register file. Captures one execute
//  bundle (up to 3 register results), converts x86 reg id + operand size into byte strobes and
//  byte-aligned data, and drives wr_en/wr_reg/wr_strb/wr_data 1..3. Bundles whose writes overlap
//  on the same register bytes are split over several cycles so program order (port1<port2<port3) holds.
// PARAMETERS
//  CNT_W  16  width of the retired-bundle counter
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, asynchronous, active-low
//  ex_valid       in   1   execute bundle valid
//  ex_ready       out  1   stage can accept bundle this cycle
//  ex_enK         in   1   K=1..3: port K carries a result
//  ex_regK        in   3   K=1..3: x86 reg id (8-bit size: 0-3=AL..BL, 4-7=AH..BH)
//  ex_sizeK       in   2   K=1..3: 00=8b, 01=16b, 10=32b, 11=illegal
//  ex_dataK       in   32  K=1..3: result, right-justified
//  wb_stall       in   1   hold: no writes, no accept
//  wb_flush       in   1   discard pending bundle
//  wr_enK         out  1   K=1..3: regfile write enable
//  wr_regK        out  3   K=1..3: physical register 0-7
//  wr_strbK       out  4   K=1..3: byte strobes
//  wr_dataK       out  32  K=1..3: aligned write data
//  retire_cnt     out  CNT_W  bundles fully written (wraps)
//  err_illegal    out  1   sticky: a captured port had size 11
// BEHAVIOUR
//  - Reset (async, rst_n=0): pend=000, bundle regs 0, all wr_en*=0, wr_reg/strb/data=0,
//    retire_cnt=0, err_illegal=0. ex_ready=1 after reset release.
//  - Capture on posedge when ex_valid&ex_ready: store reg/strb/data per port; pend[K]=ex_enK & legal size.
//  - Alignment: 32b -> strb 1111, reg=id, data as-is. 16b -> strb 0011, data {16'b0,d[15:0]}.
//    8b id<4 -> strb 0001, reg=id, data {24'b0,d[7:0]}; 8b id>=4 -> strb 0010, reg=id-4,
//    data {16'b0,d[7:0],8'b0}. Size 11 -> port dropped, err_illegal set (sticky until reset).
//  - overlap(i,j) = reg_i==reg_j && |(strb_i&strb_j).
//  - Select (comb. from registered state): port K selected iff pend[K] and no overlap with any
//    earlier pending port J<K (selected or not). wr_enK=sel[K] & !wb_stall & !wb_flush.
//  - Pass: at posedge with !wb_stall & !wb_flush, pend <= pend & ~sel (or new bundle if captured).
//    Max 3 passes (all three ports overlap); no overlap -> 1 pass.
//  - Latency: bundle captured at edge N is written into regfile at edge N+1 (no conflicts, no stall).
//  - ex_ready = !wb_stall & !wb_flush & (pend==0 | sel==pend): back-to-back bundles at full rate
//    when no splits; new bundle accepted in the same cycle as the final pass.
//  - Bundle with all enables 0 (or all illegal): captured, pend=000, counts as retired at capture.
//  - retire_cnt += 1 on the edge a bundle's last pending port is written (or empty capture);
//    wraps 2^CNT_W-1 -> 0. Flushed bundles are not counted.
//  - wb_stall: wr_en*=0, pend/bundle/counter hold; wr_reg/strb/data may stay driven.
//  - wb_flush (priority over stall): wr_en*=0, pend<=000 at edge, no capture that cycle.
//  - rst_n low mid-split: pending writes abandoned, outputs to reset values immediately.
//  - wr_reg/strb/data for unselected ports drive the stored values; only wr_en qualifies them.
// TESTING
//  1 ex1: reg=0 size=10 data=DEADBEEF, others off -> next cycle wr_en1=1 reg=0 strb=1111
//    data=DEADBEEF; retire_cnt 0->1.
//  2 ex1: reg=4 (AH) size=00 data=xxxxxx5A -> wr_reg1=0 strb=0010 data=00005A00.
//  3 ex1 reg=1 32b, ex2 reg=5 (CH) 8b, ex3 reg=1 16b -> pass1 port1 only; pass2 port2 (overlaps
//    port3 byte 1? no: port2 strb 0010 overlaps port3 0011 -> pass2 port2, pass3 port3);
//    ex_ready low 2 cycles, retire_cnt +1 after pass3.
//  4 wb_stall high during pass2 of scenario 3 for 4 cycles -> all wr_en=0, pend held, resumes
//    pass2 after release; wb_flush in pass2 -> pend=000, no further writes, cnt unchanged.
//  5 ex2 size=11 with ex1 valid 32b -> only port1 written, err_illegal=1 until rst_n;
//    retire_cnt preload via 2^CNT_W bundles -> wraps to 0.
//  6 assert rst_n=0 asynchronously mid-split -> wr_en*=0 and retire_cnt=0 before next clk edge.

Source files
------------

// File: rtl/wb_align_stage.sv
// Writeback alignment stage feeding a 3-write-port register file.
// Captures one execute bundle of up to three results, turns each x86 register
// id plus operand size into a physical register, byte strobes and byte-aligned
// data, and issues the writes. Ports whose bytes collide with an earlier port
// of the same bundle are deferred to later passes so port order is preserved.

module wb_align_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             ex_valid,
    output logic             ex_ready,

    input  logic             ex_en1,
    input  logic [2:0]       ex_reg1,
    input  logic [1:0]       ex_size1,
    input  logic [31:0]      ex_data1,

    input  logic             ex_en2,
    input  logic [2:0]       ex_reg2,
    input  logic [1:0]       ex_size2,
    input  logic [31:0]      ex_data2,

    input  logic             ex_en3,
    input  logic [2:0]       ex_reg3,
    input  logic [1:0]       ex_size3,
    input  logic [31:0]      ex_data3,

    input  logic             wb_stall,
    input  logic             wb_flush,

    output logic             wr_en1,
    output logic [2:0]       wr_reg1,
    output logic [3:0]       wr_strb1,
    output logic [31:0]      wr_data1,

    output logic             wr_en2,
    output logic [2:0]       wr_reg2,
    output logic [3:0]       wr_strb2,
    output logic [31:0]      wr_data2,

    output logic             wr_en3,
    output logic [2:0]       wr_reg3,
    output logic [3:0]       wr_strb3,
    output logic [31:0]      wr_data3,

    output logic [CNT_W-1:0] retire_cnt,
    output logic             err_illegal
);

    localparam int NP = 3;

    localparam logic [1:0] SIZE_8   = 2'b00;
    localparam logic [1:0] SIZE_16  = 2'b01;
    localparam logic [1:0] SIZE_32  = 2'b10;
    localparam logic [1:0] SIZE_BAD = 2'b11;

    // Per-port views of the flat input ports, index 0 = port 1.
    logic [NP-1:0]        in_en;
    logic [NP-1:0][2:0]   in_reg;
    logic [NP-1:0][1:0]   in_size;
    logic [NP-1:0][31:0]  in_data;
    logic [NP-1:0]        in_illegal;
    logic [NP-1:0]        new_pend;

    // Registered bundle state.
    logic [NP-1:0]        pend_q, pend_d;
    logic [NP-1:0][2:0]   reg_q, reg_d;
    logic [NP-1:0][3:0]   strb_q, strb_d;
    logic [NP-1:0][31:0]  data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    // Control derived from registered state and the hold/flush inputs.
    logic [NP-1:0]        sel;
    logic                 advance;
    logic                 capture;
    logic                 final_pass;
    logic                 empty_capture;

    assign in_en   = {ex_en3, ex_en2, ex_en1};
    assign in_reg  = {ex_reg3, ex_reg2, ex_reg1};
    assign in_size = {ex_size3, ex_size2, ex_size1};
    assign in_data = {ex_data3, ex_data2, ex_data1};

    // Physical register: the high-byte 8-bit ids (AH..BH) live in registers 0-3.
    function automatic logic [2:0] align_reg(input logic [2:0] id, input logic [1:0] size);
        logic [2:0] r;
        r = id;
        if (size == SIZE_8 && id[2]) begin
            r = {1'b0, id[1:0]};
        end
        return r;
    endfunction

    // Byte strobes for a given register id and operand size.
    function automatic logic [3:0] align_strb(input logic [2:0] id, input logic [1:0] size);
        logic [3:0] s;
        case (size)
            SIZE_32: s = 4'b1111;
            SIZE_16: s = 4'b0011;
            SIZE_8:  s = id[2] ? 4'b0010 : 4'b0001;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Right-justified result moved into the byte lanes named by the strobes.
    function automatic logic [31:0] align_data(input logic [2:0] id, input logic [1:0] size,
                                               input logic [31:0] d);
        logic [31:0] a;
        case (size)
            SIZE_32: a = d;
            SIZE_16: a = {16'b0, d[15:0]};
            SIZE_8:  a = id[2] ? {16'b0, d[7:0], 8'b0} : {24'b0, d[7:0]};
            default: a = d;
        endcase
        return a;
    endfunction

    // Which incoming ports are real, legal writes.
    always_comb begin
        in_illegal = '0;
        new_pend   = '0;
        for (int k = 0; k < NP; k++) begin
            in_illegal[k] = (in_size[k] == SIZE_BAD);
            new_pend[k]   = in_en[k] & ~in_illegal[k];
        end
    end

    // A pending port goes this pass unless an earlier pending port touches the same bytes.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NP; k++) begin
            sel[k] = pend_q[k];
            for (int j = 0; j < k; j++) begin
                if (pend_q[j] && (reg_q[j] == reg_q[k]) && (|(strb_q[j] & strb_q[k]))) begin
                    sel[k] = 1'b0;
                end
            end
        end
    end

    // Handshake and pass bookkeeping; the final pass frees the stage for a new bundle.
    always_comb begin
        advance       = ~wb_stall & ~wb_flush;
        ex_ready      = advance & ((pend_q == '0) | (sel == pend_q));
        capture       = ex_valid & ex_ready;
        final_pass    = advance & (pend_q != '0) & ((pend_q & ~sel) == '0);
        empty_capture = capture & (new_pend == '0);
    end

    // Next-state: flush wins, then capture, then retire the ports written this pass.
    always_comb begin
        pend_d = pend_q;
        reg_d  = reg_q;
        strb_d = strb_q;
        data_d = data_q;
        err_d  = err_q;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, final_pass} + {{(CNT_W-1){1'b0}}, empty_capture};
        if (wb_flush) begin
            pend_d = '0;
        end else if (capture) begin
            pend_d = new_pend;
            for (int k = 0; k < NP; k++) begin
                reg_d[k]  = align_reg(in_reg[k], in_size[k]);
                strb_d[k] = align_strb(in_reg[k], in_size[k]);
                data_d[k] = align_data(in_reg[k], in_size[k], in_data[k]);
            end
        end else if (advance) begin
            pend_d = pend_q & ~sel;
        end
        if (capture && (|(in_en & in_illegal))) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset abandons any split in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            reg_q  <= '0;
            strb_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            reg_q  <= reg_d;
            strb_q <= strb_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Register-file port drive: stored values always visible, enables gate them.
    always_comb begin
        wr_en1   = sel[0] & advance;
        wr_en2   = sel[1] & advance;
        wr_en3   = sel[2] & advance;
        wr_reg1  = reg_q[0];
        wr_reg2  = reg_q[1];
        wr_reg3  = reg_q[2];
        wr_strb1 = strb_q[0];
        wr_strb2 = strb_q[1];
        wr_strb3 = strb_q[2];
        wr_data1 = data_q[0];
        wr_data2 = data_q[1];
        wr_data3 = data_q[2];
        retire_cnt  = cnt_q;
        err_illegal = err_q;
    end

endmodule

// File: tb/tb_wb_align_stage.sv
// Testbench for wb_align_stage: directed scenarios plus randomized bundles,
// with expected register-file writes queued at capture and consumed by a monitor.

module tb_wb_align_stage;

    localparam int CNT_W   = 6;
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk = 1'b0;
    logic rst_n;
    logic ex_valid, ex_ready;
    logic wb_stall, wb_flush;
    logic [2:0]  b_en;
    logic [2:0]  b_reg  [3];
    logic [1:0]  b_size [3];
    logic [31:0] b_data [3];

    logic        wr_en1, wr_en2, wr_en3;
    logic [2:0]  wr_reg1, wr_reg2, wr_reg3;
    logic [3:0]  wr_strb1, wr_strb2, wr_strb3;
    logic [31:0] wr_data1, wr_data2, wr_data3;
    logic [CNT_W-1:0] retire_cnt;
    logic        err_illegal;

    typedef struct packed {
        logic [2:0]       en;
        logic [2:0][2:0]  rg;
        logic [2:0][3:0]  st;
        logic [2:0][31:0] dt;
    } wr_t;

    wr_t exp_q[$];
    wr_t plan_q[$];
    wr_t mon_w;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;
    bit model_err = 1'b0;
    bit rand_stall = 1'b0;

    logic [2:0]  act_en;
    logic [2:0]  act_rg [3];
    logic [3:0]  act_st [3];
    logic [31:0] act_dt [3];

    assign act_en = {wr_en3, wr_en2, wr_en1};
    assign act_rg[0] = wr_reg1;  assign act_rg[1] = wr_reg2;  assign act_rg[2] = wr_reg3;
    assign act_st[0] = wr_strb1; assign act_st[1] = wr_strb2; assign act_st[2] = wr_strb3;
    assign act_dt[0] = wr_data1; assign act_dt[1] = wr_data2; assign act_dt[2] = wr_data3;

    wb_align_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_en1(b_en[0]), .ex_reg1(b_reg[0]), .ex_size1(b_size[0]), .ex_data1(b_data[0]),
        .ex_en2(b_en[1]), .ex_reg2(b_reg[1]), .ex_size2(b_size[1]), .ex_data2(b_data[1]),
        .ex_en3(b_en[2]), .ex_reg3(b_reg[2]), .ex_size3(b_size[2]), .ex_data3(b_data[2]),
        .wb_stall(wb_stall), .wb_flush(wb_flush),
        .wr_en1(wr_en1), .wr_reg1(wr_reg1), .wr_strb1(wr_strb1), .wr_data1(wr_data1),
        .wr_en2(wr_en2), .wr_reg2(wr_reg2), .wr_strb2(wr_strb2), .wr_data2(wr_data2),
        .wr_en3(wr_en3), .wr_reg3(wr_reg3), .wr_strb3(wr_strb3), .wr_data3(wr_data3),
        .retire_cnt(retire_cnt), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: align each legal port, then peel off passes where a port goes
    // only if no earlier still-unwritten port shares a register byte with it.
    function automatic void build_plan();
        logic [2:0]  rem;
        logic [2:0]  areg [3];
        logic [3:0]  ast  [3];
        logic [31:0] adt  [3];
        wr_t w;
        bit clash;
        plan_q.delete();
        rem = '0;
        for (int k = 0; k < 3; k++) begin
            areg[k] = b_reg[k];
            ast[k]  = 4'h0;
            adt[k]  = b_data[k];
            if (b_en[k] && b_size[k] != 2'd3) begin
                rem[k] = 1'b1;
                if (b_size[k] == 2'd2) begin
                    ast[k] = 4'hF;
                end else if (b_size[k] == 2'd1) begin
                    ast[k] = 4'h3;
                    adt[k] = b_data[k] & 32'h0000FFFF;
                end else if (b_reg[k] < 3'd4) begin
                    ast[k] = 4'h1;
                    adt[k] = b_data[k] & 32'h000000FF;
                end else begin
                    ast[k]  = 4'h2;
                    areg[k] = b_reg[k] - 3'd4;
                    adt[k]  = (b_data[k] & 32'h000000FF) << 8;
                end
            end
        end
        while (rem != 3'b000) begin
            w = '0;
            for (int k = 0; k < 3; k++) begin
                if (rem[k]) begin
                    clash = 1'b0;
                    for (int j = 0; j < k; j++) begin
                        if (rem[j] && areg[j] == areg[k] && (ast[j] & ast[k]) != 4'h0) clash = 1'b1;
                    end
                    if (!clash) begin
                        w.en[k] = 1'b1;
                        w.rg[k] = areg[k];
                        w.st[k] = ast[k];
                        w.dt[k] = adt[k];
                    end
                end
            end
            rem = rem & ~w.en;
            plan_q.push_back(w);
        end
    endfunction

    task automatic set_port(input int k, input bit en, input logic [2:0] r,
                            input logic [1:0] s, input logic [31:0] d);
        b_en[k] = en; b_reg[k] = r; b_size[k] = s; b_data[k] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wb_stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    // Present the current bundle until accepted; keep<0 expects every pass,
    // otherwise only the first 'keep' passes (the rest are flushed or reset away).
    task automatic apply_stimulus(input int keep);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        ex_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ex_ready) begin
                build_plan();
                for (int k = 0; k < 3; k++) if (b_en[k] && b_size[k] == 2'd3) model_err = 1'b1;
                for (int i = 0; i < plan_q.size(); i++) begin
                    if (keep < 0 || i < keep) exp_q.push_back(plan_q[i]);
                end
                if (keep < 0) model_cnt++;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 60) begin
                    check_output("handshake_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
            next_cycle();
        end
        ex_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int waited;
        rand_stall = 1'b0;
        wb_stall = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            next_cycle();
            waited++;
        end
        if (exp_q.size() != 0) check_output({tag, "_drain_timeout"}, exp_q.size(), 0);
        next_cycle();
        next_cycle();
        check_output({tag, "_retire_cnt"}, 32'(retire_cnt), 32'(model_cnt % CNT_MOD));
        check_output({tag, "_err_illegal"}, 32'(err_illegal), 32'(model_err));
    endtask

    task automatic load_overlap_bundle();
        set_port(0, 1'b1, 3'd1, 2'd2, 32'h11223344);
        set_port(1, 1'b1, 3'd5, 2'd0, 32'hCAFE00A7);
        set_port(2, 1'b1, 3'd1, 2'd1, 32'h0BADF00D);
    endtask

    // Monitor: every cycle the DUT writes, compare against the oldest expected pass.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_stall || wb_flush) check_output("no_write_when_held", 32'(act_en), 32'd0);
            if (act_en != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_write", 32'(act_en), 32'd0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check_output("wr_en", 32'(act_en), 32'(mon_w.en));
                    for (int k = 0; k < 3; k++) begin
                        if (mon_w.en[k]) begin
                            check_output($sformatf("wr_reg%0d", k + 1), 32'(act_rg[k]), 32'(mon_w.rg[k]));
                            check_output($sformatf("wr_strb%0d", k + 1), 32'(act_st[k]), 32'(mon_w.st[k]));
                            check_output($sformatf("wr_data%0d", k + 1), act_dt[k], mon_w.dt[k]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        ex_valid = 1'b0;
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        for (int k = 0; k < 3; k++) set_port(k, 1'b0, 3'd0, 2'd0, 32'd0);
        #1 rst_n = 1'b0;
        #2;
        check_output("rst_wr_en", 32'(act_en), 32'd0);
        check_output("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        check_output("rst_err_illegal", 32'(err_illegal), 32'd0);
        check_output("rst_wr_strb1", 32'(wr_strb1), 32'd0);
        check_output("rst_wr_data1", wr_data1, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_output("rst_ex_ready", 32'(ex_ready), 32'd1);

        // 32-bit write to EAX.
        set_port(0, 1'b1, 3'd0, 2'd2, 32'hDEADBEEF);
        apply_stimulus(-1);
        check_output("s1_wr_en1", 32'(wr_en1), 32'd1);
        check_output("s1_wr_strb1", 32'(wr_strb1), 32'hF);
        check_output("s1_wr_data1", wr_data1, 32'hDEADBEEF);
        check_output("s1_cnt_before", 32'(retire_cnt), 32'd0);
        drain("s1");

        // 8-bit write to AH lands in byte 1 of register 0.
        set_port(0, 1'b1, 3'd4, 2'd0, 32'h1234565A);
        apply_stimulus(-1);
        check_output("s2_wr_reg1", 32'(wr_reg1), 32'd0);
        check_output("s2_wr_strb1", 32'(wr_strb1), 32'h2);
        check_output("s2_wr_data1", wr_data1, 32'h00005A00);
        drain("s2");

        // Three mutually overlapping ports: three passes, ready low for two cycles.
        load_overlap_bundle();
        apply_stimulus(-1);
        check_output("s3_ready_pass1", 32'(ex_ready), 32'd0);
        next_cycle();
        check_output("s3_ready_pass2", 32'(ex_ready), 32'd0);
        next_cycle();
        check_output("s3_ready_pass3", 32'(ex_ready), 32'd1);
        next_cycle();
        check_output("s3_retire_cnt", 32'(retire_cnt), 32'(model_cnt % CNT_MOD));
        drain("s3");

        // Stall for four cycles in the middle of the split.
        apply_stimulus(-1);
        next_cycle();
        wb_stall = 1'b1;
        repeat (4) begin
            #1 check_output("s4_ready_stalled", 32'(ex_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        wb_stall = 1'b0;
        drain("s4_stall");

        // Flush during the second pass: only the first pass ever reaches the file.
        apply_stimulus(1);
        @(posedge clk);
        #1 wb_flush = 1'b1;
        #1 check_output("s4_ready_flush", 32'(ex_ready), 32'd0);
        @(posedge clk);
        #1 wb_flush = 1'b0;
        #1 check_output("s4_ready_after_flush", 32'(ex_ready), 32'd1);
        repeat (3) next_cycle();
        drain("s4_flush");

        // Illegal size on port 2 is dropped and raises the sticky error.
        check_output("s5_err_before", 32'(err_illegal), 32'd0);
        set_port(0, 1'b1, 3'd2, 2'd2, 32'hA5A5A5A5);
        set_port(1, 1'b1, 3'd3, 2'd3, 32'h5A5A5A5A);
        set_port(2, 1'b0, 3'd0, 2'd0, 32'd0);
        apply_stimulus(-1);
        drain("s5");

        // Randomized bundles with random stalls; small register range to force overlaps.
        rand_stall = 1'b1;
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 3; k++) begin
                set_port(k, ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7) & 5),
                         ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                         $urandom);
            end
            apply_stimulus(-1);
        end
        drain("rand");

        // Empty bundles retire at capture; walk the counter to its maximum and wrap.
        for (int k = 0; k < 3; k++) set_port(k, 1'b0, 3'd0, 2'd0, 32'd0);
        while (model_cnt % CNT_MOD != CNT_MOD - 1) apply_stimulus(-1);
        drain("wrap_pre");
        check_output("cnt_max", 32'(retire_cnt), 32'(CNT_MOD - 1));
        apply_stimulus(-1);
        drain("wrap");
        check_output("cnt_wrapped", 32'(retire_cnt), 32'd0);

        // Asynchronous reset in the middle of a split.
        load_overlap_bundle();
        apply_stimulus(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_cnt = 0;
        model_err = 1'b0;
        #1;
        check_output("s6_wr_en", 32'(act_en), 32'd0);
        check_output("s6_retire_cnt", 32'(retire_cnt), 32'd0);
        check_output("s6_err_illegal", 32'(err_illegal), 32'd0);
        check_output("s6_wr_data2", wr_data2, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) next_cycle();
        check_output("end_queue_empty", exp_q.size(), 0);
        check_output("end_retire_cnt", 32'(retire_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
